vram_dma: RTL and testbench

VRAM_DMA -- requirements
Module: vram_dma

---
 rtl/vram_dma_pkg.sv | 24 ++
 rtl/vram_dma.sv | 113 +++++++++++
 tb/tb_vram_dma.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_dma_pkg.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// Module   : vram_dma_pkg
// Brief    : Shared GPU constants: DMA state encoding and VRAM region bases.
// Revision : 1.0
////////////////////////////////////////////////////////////////////////////////
package vram_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_RUN     = 2'd2,
        ST_FLUSH   = 2'd3
    } dma_state_t;

    localparam int unsigned LEN_WIDTH = 12;

    localparam logic [11:0] VRAM_PMF_BASE  = 12'h000;
    localparam logic [11:0] VRAM_PMB_BASE  = 12'h200;
    localparam logic [11:0] VRAM_NTBL_BASE = 12'h400;
    localparam logic [11:0] VRAM_OBM_BASE  = 12'h800;

endpackage
`default_nettype wire

// File: rtl/vram_dma.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// Module   : vram_dma
// Brief    : CPU-to-VRAM byte copier, writing only while vblank is high.
// Revision : 1.0
////////////////////////////////////////////////////////////////////////////////
module vram_dma
    import vram_dma_pkg::*;
#(
    parameter int VRAM_ADDR_WIDTH = 12,
    parameter int SRC_ADDR_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [SRC_ADDR_WIDTH-1:0]  src_base,
    input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
    input  logic [LEN_WIDTH-1:0]       length,
    input  logic                       vblank,
    output logic [SRC_ADDR_WIDTH-1:0]  src_addr,
    output logic                       src_rd,
    input  logic [7:0]                 src_data,
    output logic [7:0]                 data,
    output logic [VRAM_ADDR_WIDTH-1:0] address,
    output logic                       cs,
    output logic                       busy,
    output logic                       done
);

    dma_state_t                 r_state;
    dma_state_t                 w_state_nxt;
    logic [SRC_ADDR_WIDTH-1:0]  r_src;
    logic [VRAM_ADDR_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]       r_remaining;
    logic                       r_pending;
    logic                       r_done_empty;
    logic                       w_rd;
    logic                       w_accept;
    logic                       w_accept_empty;

    assign w_accept       = (r_state == ST_IDLE) && start && (length != '0);
    assign w_accept_empty = (r_state == ST_IDLE) && start && (length == '0);
    assign w_rd           = (r_state == ST_RUN) && vblank && (r_remaining != '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: begin
                if (vblank) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_rd && (r_remaining == LEN_WIDTH'(1))) begin
                    w_state_nxt = ST_FLUSH;
                end else if (!vblank) begin
                    w_state_nxt = ST_WAIT_VB;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_remaining  <= '0;
            r_pending    <= 1'b0;
            r_done_empty <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            // The read issued this cycle becomes next cycle's VRAM write.
            r_pending    <= w_rd;
            r_done_empty <= w_accept_empty;
            if (w_accept) begin
                r_src       <= src_base;
                r_dst       <= dst_base;
                r_remaining <= length;
            end else begin
                if (w_rd) begin
                    r_src       <= r_src + SRC_ADDR_WIDTH'(1);
                    r_remaining <= r_remaining - LEN_WIDTH'(1);
                end
                if (r_pending) begin
                    r_dst <= r_dst + VRAM_ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign src_rd   = w_rd;
    assign src_addr = r_src;
    assign cs       = r_pending;
    assign address  = r_dst;
    // Gated so the write bus stays quiet outside a write cycle.
    assign data     = r_pending ? src_data : 8'h00;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_FLUSH) || r_done_empty;

endmodule
`default_nettype wire

// File: tb/tb_vram_dma.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// Module   : tb_vram_dma
// Brief    : Self-checking bench for vram_dma against a transfer-level model.
// Revision : 1.0
////////////////////////////////////////////////////////////////////////////////
module tb_vram_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_base;
    logic [11:0] dst_base;
    logic [11:0] length;
    logic        vblank;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data;
    logic [7:0]  data;
    logic [11:0] address;
    logic        cs;
    logic        busy;
    logic        done;

    vram_dma #(
        .VRAM_ADDR_WIDTH(12),
        .SRC_ADDR_WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src_base(src_base),
        .dst_base(dst_base),
        .length  (length),
        .vblank  (vblank),
        .src_addr(src_addr),
        .src_rd  (src_rd),
        .src_data(src_data),
        .data    (data),
        .address (address),
        .cs      (cs),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] srcmem [0:65535];

    // Source memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        src_data <= src_rd ? srcmem[src_addr] : 8'($urandom);
    end

    logic [11:0] obs_a[$];
    logic [7:0]  obs_d[$];
    int          obs_c[$];
    int          done_cnt;
    int          done_cyc;
    logic        done_cs;
    int          rd_cnt;
    int          start_cyc;

    always @(negedge clk) begin
        if (cs) begin
            obs_a.push_back(address);
            obs_d.push_back(data);
            obs_c.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_cs  = cs;
        end
        if (src_rd) rd_cnt = rd_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask

    // mode 0: vblank always high; 1: low for 5 cycles after start;
    // 2: random vblank; 3: vblank drops for 4 cycles once 3 reads issued.
    task automatic do_xfer(input logic [15:0] s, input logic [11:0] d, input logic [11:0] l,
                           input int mode, input bit ign, input int exp_first, input string nm);
        int  low_cnt = 0;
        bit  seen    = 0;
        bit  contig  = 1;
        obs_a.delete(); obs_d.delete(); obs_c.delete();
        done_cnt = 0; rd_cnt = 0; done_cyc = -1; done_cs = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; src_base = s; dst_base = d; length = l;
        vblank = (mode == 1) ? 1'b0 : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        for (int k = 1; k < 600 && !seen; k++) begin
            @(posedge clk); #1;
            start    = 1'b0;
            src_base = 16'($urandom);
            dst_base = 12'($urandom);
            length   = 12'($urandom);
            if (ign && busy && ($urandom_range(0, 2) == 0)) start = 1'b1;
            case (mode)
                1: vblank = (cyc - start_cyc) >= 5;
                2: vblank = ($urandom_range(0, 3) != 0);
                3: begin
                    if (rd_cnt >= 3 && low_cnt < 4) begin
                        vblank = 1'b0;
                        low_cnt++;
                    end else begin
                        vblank = 1'b1;
                    end
                end
                default: vblank = 1'b1;
            endcase
            @(negedge clk); #1;
            if (k == 1) check({nm, " busy_after_start"}, 32'(busy), 32'(l != 0));
            if (done_cnt != 0) seen = 1;
        end
        if (!seen) check({nm, " done_timeout"}, 0, 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0; vblank = 1'b1;
        end
        @(negedge clk); #1;
        check({nm, " write_count"}, obs_a.size(), 32'(l));
        check({nm, " done_count"}, done_cnt, 1);
        check({nm, " busy_at_end"}, 32'(busy), 0);
        if (l == 0) begin
            check({nm, " empty_done_cycle"}, done_cyc, start_cyc + 1);
        end else begin
            check({nm, " done_with_cs"}, 32'(done_cs), 1);
            if (obs_c.size() > 0) check({nm, " done_on_last_cs"}, done_cyc, obs_c[obs_c.size()-1]);
        end
        for (int k = 0; k < obs_a.size() && k < int'(l); k++) begin
            logic [11:0] ea;
            logic [15:0] sa;
            ea = d + 12'(k);
            sa = s + 16'(k);
            check({nm, " addr"}, obs_a[k], ea);
            check({nm, " data"}, obs_d[k], srcmem[sa]);
        end
        if (exp_first >= 0 && obs_c.size() > 0)
            check({nm, " first_write_latency"}, obs_c[0] - start_cyc, exp_first);
        if (mode == 0) begin
            for (int k = 1; k < obs_c.size(); k++)
                if (obs_c[k] != obs_c[k-1] + 1) contig = 0;
            check({nm, " back_to_back"}, 32'(contig), 1);
        end
        if (mode == 3 && obs_c.size() >= 4)
            check({nm, " paused"}, 32'(obs_c[3] - obs_c[2] > 1), 1);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " busy"}, 32'(busy), 0);
        check({nm, " done"}, 32'(done), 0);
        check({nm, " cs"}, 32'(cs), 0);
        check({nm, " src_rd"}, 32'(src_rd), 0);
        check({nm, " data"}, 32'(data), 0);
        check({nm, " address"}, 32'(address), 0);
        check({nm, " src_addr"}, 32'(src_addr), 0);
    endtask

    typedef struct {
        logic [15:0] s;
        logic [11:0] d;
        logic [11:0] l;
        int          mode;
        bit          ign;
        int          exp_first;
        int          exp_n;
        logic [11:0] exp_last;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n_before;
        bit got2;
        for (int i = 0; i < 65536; i++) srcmem[i] = 8'($urandom);
        srcmem[16'h1000] = 8'h11;
        srcmem[16'h1001] = 8'h22;
        srcmem[16'h1002] = 8'h33;
        srcmem[16'h1003] = 8'h44;

        vecs[0] = '{16'h1000, 12'h400, 12'd4, 0, 1'b0, 3,  4, 12'h403};
        vecs[1] = '{16'h2000, 12'h200, 12'd2, 1, 1'b0, 7,  2, 12'h201};
        vecs[2] = '{16'h3000, 12'h800, 12'd6, 3, 1'b0, 3,  6, 12'h805};
        vecs[3] = '{16'h4000, 12'hFFE, 12'd4, 0, 1'b0, 3,  4, 12'h001};
        vecs[4] = '{16'hFFFE, 12'h100, 12'd3, 0, 1'b0, 3,  3, 12'h102};
        vecs[5] = '{16'h5000, 12'h000, 12'd0, 0, 1'b0, -1, 0, 12'h000};
        vecs[6] = '{16'h6000, 12'h600, 12'd5, 0, 1'b1, 3,  5, 12'h604};

        rst = 1'b1; start = 1'b0; vblank = 1'b0;
        src_base = '0; dst_base = '0; length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_xfer(vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].mode, vecs[i].ign,
                    vecs[i].exp_first, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table_count", i), obs_a.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0 && obs_a.size() > 0)
                check($sformatf("vec%0d table_last_addr", i), obs_a[obs_a.size()-1], vecs[i].exp_last);
        end
        if (obs_d.size() >= 0) begin
            do_xfer(16'h1000, 12'h400, 12'd4, 0, 1'b0, 3, "bytes");
            if (obs_d.size() == 4) begin
                check("bytes d0", obs_d[0], 8'h11);
                check("bytes d3", obs_d[3], 8'h44);
            end
        end

        // Reset in the middle of an 8-byte transfer.
        obs_a.delete(); obs_d.delete(); obs_c.delete();
        done_cnt = 0; rd_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; src_base = 16'h7000; dst_base = 12'h300; length = 12'd8; vblank = 1'b1;
        got2 = 0;
        for (int k = 0; k < 50 && !got2; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk); #1;
            if (obs_a.size() >= 2) got2 = 1;
        end
        if (!got2) check("rst_mid wait_two_writes", 0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        n_before = obs_a.size();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check_idle_outputs("rst_mid");
        repeat (6) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        check("rst_mid no_more_writes", obs_a.size(), n_before);
        check("rst_mid no_done", done_cnt, 0);
        do_xfer(16'h7100, 12'h310, 12'd5, 0, 1'b0, 3, "after_rst");

        for (int i = 0; i < 20; i++) begin
            logic [11:0] rl;
            rl = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 40));
            do_xfer(16'($urandom), 12'($urandom), rl, 2, 1'($urandom_range(0, 1)), -1,
                    $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
